// File: rtl/jtag_l2_test_pkg.sv
// Shared types and constants for the JTAG-to-L2 test block: instruction codes,
// DR widths, the MEMACC field layout and the TAP controller state encoding.
package jtag_l2_test_pkg;

    localparam int unsigned IR_W = 5;

    localparam logic [IR_W-1:0] INSTR_IDCODE  = 5'h02;
    localparam logic [IR_W-1:0] INSTR_MEMACC  = 5'h04;
    localparam logic [IR_W-1:0] INSTR_CONFREG = 5'h06;
    localparam logic [IR_W-1:0] INSTR_BYPASS  = 5'h1F;
    localparam logic [IR_W-1:0] IR_CAPTURE    = 5'b00001;

    localparam int unsigned IDCODE_DR_W  = 32;
    localparam int unsigned MEMACC_DR_W  = 65;
    localparam int unsigned CONFREG_DR_W = 9;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } memacc_t;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET,
        RUN_TEST_IDLE,
        SELECT_DR_SCAN,
        CAPTURE_DR,
        SHIFT_DR,
        EXIT1_DR,
        PAUSE_DR,
        EXIT2_DR,
        UPDATE_DR,
        SELECT_IR_SCAN,
        CAPTURE_IR,
        SHIFT_IR,
        EXIT1_IR,
        PAUSE_IR,
        EXIT2_IR,
        UPDATE_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_MEMACC,
        DR_CONFREG
    } dr_sel_e;

    // Unknown instruction codes fall back to the bypass register.
    function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir);
        case (ir)
            INSTR_IDCODE:  return DR_IDCODE;
            INSTR_MEMACC:  return DR_MEMACC;
            INSTR_CONFREG: return DR_CONFREG;
            default:       return DR_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/jtag_l2_tap.sv
// IEEE 1149.1 TAP for the L2 test block (TCK domain): controller FSM, IR,
// IDCODE/BYPASS/CONFREG/MEMACC data registers and the MEMACC request holding register.
module jtag_l2_tap
    import jtag_l2_test_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h1024_5BDF,
    parameter int unsigned IR_WIDTH     = 5
) (
    input  logic        tck,
    input  logic        trst_n,
    input  logic        tms,
    input  logic        tdi,
    output logic        tdo,
    input  logic        busy,
    input  logic [31:0] rdata,
    output memacc_t     req,
    output logic        req_tgl
);

    tap_state_e state_q, state_d;

    logic [IR_WIDTH-1:0]    ir_shift_q;
    logic [IR_WIDTH-1:0]    ir_q;
    logic [MEMACC_DR_W-1:0] dr_q;
    logic [CONFREG_DR_W-1:0] confreg_q;
    memacc_t                req_q;
    logic                   req_tgl_q;
    dr_sel_e                dr_sel;
    memacc_t                capture_val;

    assign dr_sel      = decode_ir(IR_W'(ir_q));
    assign capture_val = {busy, req_q.addr, rdata};
    assign req         = req_q;
    assign req_tgl     = req_tgl_q;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) state_q <= TEST_LOGIC_RESET;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_LOGIC_RESET: state_d = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   state_d = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       state_d = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   state_d = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_shift_q <= '0;
            ir_q       <= IR_WIDTH'(INSTR_IDCODE);
        end else begin
            case (state_q)
                TEST_LOGIC_RESET: ir_q       <= IR_WIDTH'(INSTR_IDCODE);
                CAPTURE_IR:       ir_shift_q <= IR_WIDTH'(IR_CAPTURE);
                SHIFT_IR:         ir_shift_q <= {tdi, ir_shift_q[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_q       <= ir_shift_q;
                default:          ;
            endcase
        end
    end

    // One shared shift register; each instruction only shifts its own low slice.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            dr_q      <= '0;
            confreg_q <= '0;
            req_q     <= '0;
            req_tgl_q <= 1'b0;
        end else begin
            case (state_q)
                CAPTURE_DR: begin
                    case (dr_sel)
                        DR_IDCODE:  dr_q <= MEMACC_DR_W'(IDCODE_VALUE);
                        DR_MEMACC:  dr_q <= capture_val;
                        DR_CONFREG: dr_q <= MEMACC_DR_W'(confreg_q);
                        default:    dr_q <= '0;
                    endcase
                end
                SHIFT_DR: begin
                    case (dr_sel)
                        DR_IDCODE:  dr_q[IDCODE_DR_W-1:0]  <= {tdi, dr_q[IDCODE_DR_W-1:1]};
                        DR_MEMACC:  dr_q                   <= {tdi, dr_q[MEMACC_DR_W-1:1]};
                        DR_CONFREG: dr_q[CONFREG_DR_W-1:0] <= {tdi, dr_q[CONFREG_DR_W-1:1]};
                        default:    dr_q[0]                <= tdi;
                    endcase
                end
                UPDATE_DR: begin
                    case (dr_sel)
                        DR_MEMACC: begin
                            req_q     <= dr_q;
                            req_tgl_q <= ~req_tgl_q;
                        end
                        DR_CONFREG: confreg_q <= dr_q[CONFREG_DR_W-1:0];
                        default:    ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n)                 tdo <= 1'b0;
        else if (state_q == SHIFT_IR) tdo <= ir_shift_q[0];
        else if (state_q == SHIFT_DR) tdo <= dr_q[0];
        else                          tdo <= 1'b0;
    end

endmodule

// File: rtl/jtag_l2_test.sv
// JTAG-to-L2 test block top: TAP instance, toggle CDC in both directions and the L2 SRAM.
// Optional macro JTAG_L2_BUSY_EN reports an unacknowledged request in MEMACC capture bit 64.
module jtag_l2_test
    import jtag_l2_test_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h1024_5BDF,
    parameter int unsigned IR_WIDTH     = 5,
    parameter int unsigned MEM_WORDS    = 256
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic jtag_tck_i,
    input  logic jtag_trst_ni,
    input  logic jtag_tms_i,
    input  logic jtag_tdi_i,
    output logic jtag_tdo_o
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    memacc_t     req;
    logic        req_tgl;
    logic        busy;
    logic [31:0] rdata_tck_q;

    jtag_l2_tap #(
        .IDCODE_VALUE (IDCODE_VALUE),
        .IR_WIDTH     (IR_WIDTH)
    ) u_tap (
        .tck     (jtag_tck_i),
        .trst_n  (jtag_trst_ni),
        .tms     (jtag_tms_i),
        .tdi     (jtag_tdi_i),
        .tdo     (jtag_tdo_o),
        .busy    (busy),
        .rdata   (rdata_tck_q),
        .req     (req),
        .req_tgl (req_tgl)
    );

    logic          req_sync1_q, req_sync2_q, req_prev_q;
    logic [2:0]    prime_q;
    logic          ack_tgl_q;
    logic [31:0]   rdata_q;
    logic          access;
    logic [AW-1:0] word_idx;
    logic [31:0]   mem [MEM_WORDS];

    // Upper address bits are simply truncated, so the index wraps modulo MEM_WORDS.
    assign word_idx = AW'(req.addr >> 2);
    assign access   = prime_q[2] && (req_sync2_q != req_prev_q);

    // After rst_n the edge detector only tracks for three cycles, so a toggle made
    // during reset is absorbed (and acknowledged) instead of being executed.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            req_sync1_q <= 1'b0;
            req_sync2_q <= 1'b0;
            req_prev_q  <= 1'b0;
            prime_q     <= '0;
            ack_tgl_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            req_sync1_q <= req_tgl;
            req_sync2_q <= req_sync1_q;
            req_prev_q  <= req_sync2_q;
            prime_q     <= {prime_q[1:0], 1'b1};
            if (!prime_q[2]) begin
                ack_tgl_q <= req_sync2_q;
            end else if (access) begin
                ack_tgl_q <= req_sync2_q;
                if (!req.we) rdata_q <= mem[word_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (access && req.we) mem[word_idx] <= req.data;
    end

    logic ack_sync1_q, ack_sync2_q, ack_prev_q;

    always_ff @(posedge jtag_tck_i or negedge jtag_trst_ni) begin
        if (!jtag_trst_ni) begin
            ack_sync1_q <= 1'b0;
            ack_sync2_q <= 1'b0;
            ack_prev_q  <= 1'b0;
            rdata_tck_q <= '0;
        end else begin
            ack_sync1_q <= ack_tgl_q;
            ack_sync2_q <= ack_sync1_q;
            ack_prev_q  <= ack_sync2_q;
            if (ack_sync2_q != ack_prev_q) rdata_tck_q <= rdata_q;
        end
    end

`ifdef JTAG_L2_BUSY_EN
    assign busy = req_tgl ^ ack_sync2_q;
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_l2_test.sv
// Directed self-checking bench for jtag_l2_test: TAP reset, IR capture, BYPASS,
// IDCODE, CONFREG and MEMACC write/read including address wrap and rst_n gating.
module tb_jtag_l2_test;

    logic clk_i = 1'b0;
    logic rst_n = 1'b0;
    logic tck = 1'b0;
    logic trst_n = 1'b0;
    logic tms = 1'b1;
    logic tdi = 1'b0;
    logic tdo;

    int checks = 0;
    int errors = 0;

`ifdef JTAG_L2_BUSY_EN
    localparam logic BUSY_EXP = 1'b1;
`else
    localparam logic BUSY_EXP = 1'b0;
`endif

    jtag_l2_test u_dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .jtag_tck_i   (tck),
        .jtag_trst_ni (trst_n),
        .jtag_tms_i   (tms),
        .jtag_tdi_i   (tdi),
        .jtag_tdo_o   (tdo)
    );

    // System clock period 30517 time units (30.517 us at 1 ns units); TCK period 1000.
    always begin
        #15259 clk_i = 1'b1;
        #15258 clk_i = 1'b0;
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // TDO is sampled mid-low-phase, well after the falling edge that updates it.
    task automatic tck_step(input logic t_ms, input logic t_di, output logic t_do);
        tms = t_ms;
        tdi = t_di;
        #250;
        t_do = tdo;
        tck = 1'b1;
        #500;
        tck = 1'b0;
        #250;
    endtask

    task automatic idle(input int n);
        logic b;
        for (int i = 0; i < n; i++) tck_step(1'b0, 1'b0, b);
    endtask

    task automatic scan_ir(input logic [4:0] ir, output logic [4:0] cap);
        logic b;
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        for (int i = 0; i < 5; i++) begin
            tck_step(i == 4, ir[i], b);
            cap[i] = b;
        end
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
    endtask

    task automatic scan_dr(input int n, input logic [64:0] din, output logic [64:0] dout);
        logic b;
        dout = '0;
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tck_step(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tck_step(1'b1, 1'b0, b);
        tck_step(1'b0, 1'b0, b);
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
        logic [64:0] d;
        scan_dr(65, {1'b1, addr, data}, d);
        idle(200);
    endtask

    task automatic mem_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        logic [64:0] d;
        scan_dr(65, {1'b0, addr, 32'h0}, d);
        idle(200);
        scan_dr(65, {1'b0, addr, 32'h0}, d);
        check({tag, "_data"}, 65'(d[31:0]), 65'(exp));
        check({tag, "_addr"}, 65'(d[63:32]), 65'(addr));
        check({tag, "_status"}, 65'(d[64]), 65'(1'b0));
        idle(200);
    endtask

    initial begin
        logic [4:0]  cap;
        logic [64:0] d;

        #3000;
        check("tdo_reset", 65'(tdo), 65'(1'b0));
        trst_n = 1'b1;
        repeat (5) tck_step(1'b1, 1'b0, cap[0]);
        tck_step(1'b0, 1'b0, cap[0]);
        scan_dr(32, 65'h0, d);
        check("tlr_idcode", 65'(d[31:0]), 65'h1024_5BDF);

        scan_ir(5'h1F, cap);
        check("ir_capture", 65'(cap), 65'h01);
        scan_dr(9, 65'h0A5, d);
        check("bypass_1f", 65'(d[8:0]), 65'h14A);

        scan_ir(5'h02, cap);
        check("ir_capture2", 65'(cap), 65'h01);
        scan_dr(32, 65'h0, d);
        check("idcode", 65'(d[31:0]), 65'h1024_5BDF);

        scan_ir(5'h0A, cap);
        scan_dr(9, 65'h0A5, d);
        check("bypass_0a", 65'(d[8:0]), 65'h14A);

        scan_ir(5'h06, cap);
        scan_dr(9, 65'h002, d);
        check("confreg_init", 65'(d[8:0]), 65'h000);
        scan_dr(9, 65'h002, d);
        check("confreg_rb", 65'(d[8:0]), 65'h002);
        trst_n = 1'b0;
        #2000;
        trst_n = 1'b1;
        tck_step(1'b0, 1'b0, cap[0]);
        scan_ir(5'h06, cap);
        scan_dr(9, 65'h0, d);
        check("confreg_trst", 65'(d[8:0]), 65'h000);

        rst_n = 1'b1;
        idle(200);
        scan_ir(5'h04, cap);
        scan_dr(65, {1'b1, 32'h0, 32'hABBA_ABBA}, d);
        scan_dr(65, {1'b1, 32'h0, 32'hABBA_ABBA}, d);
        check("busy_set", 65'(d[64]), 65'(BUSY_EXP));
        idle(200);
        scan_dr(65, {1'b1, 32'h0, 32'hABBA_ABBA}, d);
        check("busy_clr", 65'(d[64]), 65'(1'b0));
        idle(200);
        mem_read(32'h0, 32'hABBA_ABBA, "rd0");

        mem_write(32'h400, 32'h1234_5678);
        mem_read(32'h0, 32'h1234_5678, "rd_wrap");
        mem_write(32'h8, 32'hCAFE_F00D);
        mem_read(32'h8, 32'hCAFE_F00D, "rd8");
        mem_read(32'h0, 32'h1234_5678, "rd0_keep");

        rst_n = 1'b0;
        idle(10);
        mem_write(32'h0, 32'hDEAD_BEEF);
        rst_n = 1'b1;
        idle(200);
        mem_read(32'h0, 32'h1234_5678, "rd_gated");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
